decode_stage_pipe: RTL and testbench

//  Parametrised pipelined decode stage. Sits between the IF/ID and EX stages.

---
 rtl/decode_stage_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: operand read with forwarding, load-use/flag interlock,
// branch resolution in ID and a registered ID/EX bank with a sticky halt state.
module decode_stage_pipe #(
  parameter int unsigned  DATA_W   = 16,
  parameter int unsigned  NUM_REGS = 16,
  parameter int unsigned  BR_IMM_W = 9,
  parameter bit           FWD_EN   = 1'b1,
  localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_valid_i,
  input  logic [15:0]       if_instr_i,
  input  logic [DATA_W-1:0] if_pc_plus2_i,
  output logic              id_ready_o,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_reg_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ex_fwd_en_i,
  input  logic [REG_AW-1:0] ex_fwd_reg_i,
  input  logic [DATA_W-1:0] ex_fwd_data_i,
  input  logic              ex_flag_pend_i,
  input  logic              z_flag_i,
  input  logic              n_flag_i,
  input  logic              v_flag_i,
  output logic              br_taken_o,
  output logic [DATA_W-1:0] br_addr_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_alu_a_o,
  output logic [DATA_W-1:0] ex_alu_b_o,
  output logic [DATA_W-1:0] ex_sw_data_o,
  output logic [3:0]        ex_alu_op_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_reg_write_o,
  output logic [REG_AW-1:0] ex_dst_reg_o,
  output logic              ex_en_z_o,
  output logic              ex_en_n_o,
  output logic              ex_en_v_o,
  output logic              hlt_o
);

  localparam logic [3:0] AluAdd = 4'b0000;

  typedef enum logic {StRun, StHalted} state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] sw_data;
    logic [3:0]        alu_op;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] dst;
    logic              en_z;
    logic              en_n;
    logic              en_v;
  } idex_t;

  state_e            state_q, state_d;
  idex_t             ex_q, ex_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic [3:0]        op;
  logic [2:0]        ccc;
  logic [REG_AW-1:0] rd, rs, rt;
  logic is_alu, is_lw, is_sw, is_addi, is_movi, is_b, is_br, is_pcs, is_hlt;

  assign op  = if_instr_i[15:12];
  assign ccc = if_instr_i[11:9];
  assign rd  = if_instr_i[8 +: REG_AW];
  assign rs  = if_instr_i[4 +: REG_AW];
  assign rt  = if_instr_i[0 +: REG_AW];

  assign is_alu  = ~op[3];
  assign is_lw   = (op == 4'b1000);
  assign is_sw   = (op == 4'b1001);
  assign is_addi = (op == 4'b1010);
  assign is_movi = (op == 4'b1011);
  assign is_b    = (op == 4'b1100);
  assign is_br   = (op == 4'b1101);
  assign is_pcs  = (op == 4'b1110);
  assign is_hlt  = (op == 4'b1111);

  // Source slots: 0 = rs, 1 = rt, 2 = rd (store data).
  logic [2:0][REG_AW-1:0] src;
  logic [2:0]             src_used, lu_hit, raw_hit;
  logic [DATA_W-1:0]      src_val [3];

  assign src[0]      = rs;
  assign src[1]      = rt;
  assign src[2]      = rd;
  assign src_used[0] = is_alu | is_lw | is_sw | is_addi | is_br;
  assign src_used[1] = is_alu;
  assign src_used[2] = is_sw;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      // Later assignments win: R0 > EX forward > WB write-through > regfile.
      src_val[i] = rf_q[src[i]];
      if (wb_en_i && wb_reg_i == src[i]) src_val[i] = wb_data_i;
      if (FWD_EN && ex_fwd_en_i && ex_fwd_reg_i == src[i]) src_val[i] = ex_fwd_data_i;
      if (src[i] == '0) src_val[i] = '0;

      lu_hit[i]  = src_used[i] && (src[i] != '0) && ex_q.valid && ex_q.mem_read &&
                   (ex_q.dst == src[i]);
      raw_hit[i] = !FWD_EN && src_used[i] && (src[i] != '0) &&
                   ((ex_fwd_en_i && ex_fwd_reg_i == src[i]) ||
                    (wb_en_i && wb_reg_i == src[i]));
    end
  end

  logic cond, flag_haz, run, stall, accept;

  always_comb begin
    case (ccc)
      3'b000:  cond = ~z_flag_i;
      3'b001:  cond = z_flag_i;
      3'b010:  cond = ~z_flag_i & (n_flag_i ~^ v_flag_i);
      3'b011:  cond = n_flag_i ^ v_flag_i;
      3'b100:  cond = n_flag_i ~^ v_flag_i;
      3'b101:  cond = z_flag_i | (n_flag_i ^ v_flag_i);
      3'b110:  cond = v_flag_i;
      default: cond = 1'b1;
    endcase
  end

  assign flag_haz   = (is_b | is_br) && (ccc != 3'b111) && ex_flag_pend_i;
  assign run        = rst_ni && (state_q == StRun);
  assign stall      = if_valid_i && run && ((|lu_hit) || (|raw_hit) || flag_haz);
  assign id_ready_o = run && !stall;
  assign accept     = run && if_valid_i && !stall;
  assign br_taken_o = accept && (is_b || is_br) && cond;

  logic [BR_IMM_W-1:0] br_imm;
  logic [DATA_W-1:0]   br_off, imm4, imm8;

  assign br_imm    = if_instr_i[BR_IMM_W-1:0];
  assign br_off    = {{(DATA_W-BR_IMM_W-1){br_imm[BR_IMM_W-1]}}, br_imm, 1'b0};
  assign br_addr_o = is_br ? src_val[0] : if_pc_plus2_i + br_off;
  assign imm4      = {{(DATA_W-4){if_instr_i[3]}}, if_instr_i[3:0]};
  assign imm8      = {{(DATA_W-8){1'b0}}, if_instr_i[7:0]};

  // Branches and HLT are resolved here and enter EX as bubbles.
  always_comb begin
    ex_d = '0;
    if (accept && !(is_b || is_br || is_hlt)) begin
      ex_d.valid     = 1'b1;
      ex_d.reg_write = 1'b1;
      ex_d.dst       = rd;
      ex_d.alu_op    = AluAdd;
      if (is_alu) begin
        ex_d.alu_a  = src_val[0];
        ex_d.alu_b  = src_val[1];
        ex_d.alu_op = op;
        ex_d.en_z   = 1'b1;
        ex_d.en_n   = 1'b1;
        ex_d.en_v   = (op[2:1] == 2'b00);
      end else if (is_lw) begin
        ex_d.alu_a      = src_val[0];
        ex_d.alu_b      = imm4;
        ex_d.mem_read   = 1'b1;
        ex_d.mem_to_reg = 1'b1;
      end else if (is_sw) begin
        ex_d.alu_a     = src_val[0];
        ex_d.alu_b     = imm4;
        ex_d.sw_data   = src_val[2];
        ex_d.mem_write = 1'b1;
        ex_d.reg_write = 1'b0;
        ex_d.dst       = '0;
      end else if (is_addi) begin
        ex_d.alu_a = src_val[0];
        ex_d.alu_b = imm4;
        ex_d.en_z  = 1'b1;
        ex_d.en_n  = 1'b1;
        ex_d.en_v  = 1'b1;
      end else if (is_movi) begin
        ex_d.alu_b = imm8;
      end else if (is_pcs) begin
        ex_d.alu_a = if_pc_plus2_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept && is_hlt) state_d = StHalted;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StRun;
      ex_q    <= '0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      if (wb_en_i && wb_reg_i != '0) rf_q[wb_reg_i] <= wb_data_i;
    end
  end

  assign hlt_o           = (state_q == StHalted);
  assign ex_valid_o      = ex_q.valid;
  assign ex_alu_a_o      = ex_q.alu_a;
  assign ex_alu_b_o      = ex_q.alu_b;
  assign ex_sw_data_o    = ex_q.sw_data;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_dst_reg_o    = ex_q.dst;
  assign ex_en_z_o       = ex_q.en_z;
  assign ex_en_n_o       = ex_q.en_n;
  assign ex_en_v_o       = ex_q.en_v;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus a randomized run against an
// instruction-level reference model (forwarding instance), and a no-forwarding instance.
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, if_valid, wb_en, ex_fwd_en, ex_flag_pend, z_f, n_f, v_f;
  logic [15:0] if_instr, if_pc2, wb_data, ex_fwd_data;
  logic [3:0]  wb_reg, ex_fwd_reg;

  logic        id_ready, br_taken, ex_valid, ex_mr, ex_mw, ex_m2r, ex_rw, ex_ez, ex_en, ex_ev, hlt;
  logic [15:0] br_addr, ex_a, ex_b, ex_sw;
  logic [3:0]  ex_op, ex_dst;

  logic        nf_id_ready, nf_br_taken, nf_ex_valid, nf_mr, nf_mw, nf_m2r, nf_rw;
  logic        nf_ez, nf_en, nf_ev, nf_hlt;
  logic [15:0] nf_br_addr, nf_ex_a, nf_ex_b, nf_ex_sw;
  logic [3:0]  nf_ex_op, nf_ex_dst;

  decode_stage_pipe #(.FWD_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .if_instr_i(if_instr),
    .if_pc_plus2_i(if_pc2), .id_ready_o(id_ready), .wb_en_i(wb_en), .wb_reg_i(wb_reg),
    .wb_data_i(wb_data), .ex_fwd_en_i(ex_fwd_en), .ex_fwd_reg_i(ex_fwd_reg),
    .ex_fwd_data_i(ex_fwd_data), .ex_flag_pend_i(ex_flag_pend), .z_flag_i(z_f),
    .n_flag_i(n_f), .v_flag_i(v_f), .br_taken_o(br_taken), .br_addr_o(br_addr),
    .ex_valid_o(ex_valid), .ex_alu_a_o(ex_a), .ex_alu_b_o(ex_b), .ex_sw_data_o(ex_sw),
    .ex_alu_op_o(ex_op), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw),
    .ex_mem_to_reg_o(ex_m2r), .ex_reg_write_o(ex_rw), .ex_dst_reg_o(ex_dst),
    .ex_en_z_o(ex_ez), .ex_en_n_o(ex_en), .ex_en_v_o(ex_ev), .hlt_o(hlt)
  );

  decode_stage_pipe #(.FWD_EN(1'b0)) u_dut_nf (
    .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .if_instr_i(if_instr),
    .if_pc_plus2_i(if_pc2), .id_ready_o(nf_id_ready), .wb_en_i(wb_en), .wb_reg_i(wb_reg),
    .wb_data_i(wb_data), .ex_fwd_en_i(ex_fwd_en), .ex_fwd_reg_i(ex_fwd_reg),
    .ex_fwd_data_i(ex_fwd_data), .ex_flag_pend_i(ex_flag_pend), .z_flag_i(z_f),
    .n_flag_i(n_f), .v_flag_i(v_f), .br_taken_o(nf_br_taken), .br_addr_o(nf_br_addr),
    .ex_valid_o(nf_ex_valid), .ex_alu_a_o(nf_ex_a), .ex_alu_b_o(nf_ex_b),
    .ex_sw_data_o(nf_ex_sw), .ex_alu_op_o(nf_ex_op), .ex_mem_read_o(nf_mr),
    .ex_mem_write_o(nf_mw), .ex_mem_to_reg_o(nf_m2r), .ex_reg_write_o(nf_rw),
    .ex_dst_reg_o(nf_ex_dst), .ex_en_z_o(nf_ez), .ex_en_n_o(nf_en), .ex_en_v_o(nf_ev),
    .hlt_o(nf_hlt)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] a, b, sw;
    logic [3:0]  op;
    logic        mr, mw, m2r, rw;
    logic [3:0]  dst;
    logic        ez, en, ev;
  } bank_t;

  bank_t obs;
  assign obs = {ex_valid, ex_a, ex_b, ex_sw, ex_op, ex_mr, ex_mw, ex_m2r, ex_rw, ex_dst,
                ex_ez, ex_en, ex_ev};

  int chk = 0;
  int err = 0;

  // Reference model state
  int          rf_m [16];
  bank_t       mex, nx;
  bit          halted_m, e_ready, e_brt, e_halt;
  logic [15:0] e_bra;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc2 = '0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    ex_fwd_en = 1'b0; ex_fwd_reg = '0; ex_fwd_data = '0;
    ex_flag_pend = 1'b0; z_f = 1'b0; n_f = 1'b0; v_f = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int mval(input int r);
    if (r == 0) return 0;
    if (ex_fwd_en && int'(ex_fwd_reg) == r) return int'(ex_fwd_data);
    if (wb_en && int'(wb_reg) == r) return int'(wb_data);
    return rf_m[r];
  endfunction

  // Predicts this cycle's combinational outputs and the next ID/EX contents.
  task automatic predict();
    int op, rd, rs, rt, ccc, imm, off, i4;
    bit u_rs, u_rt, u_rd, hz, taken, acc;
    op = int'(if_instr[15:12]); rd = int'(if_instr[11:8]);
    rs = int'(if_instr[7:4]);   rt = int'(if_instr[3:0]);
    ccc = int'(if_instr[11:9]);
    u_rs = (op <= 10) || (op == 13);
    u_rt = (op < 8);
    u_rd = (op == 9);
    hz = 1'b0;
    if (mex.valid && mex.mr && mex.dst != 0)
      hz = (u_rs && rs == int'(mex.dst)) || (u_rt && rt == int'(mex.dst)) ||
           (u_rd && rd == int'(mex.dst));
    if ((op == 12 || op == 13) && ccc != 7 && ex_flag_pend) hz = 1'b1;
    e_ready = rst_n && !halted_m && !(if_valid && hz);
    acc = rst_n && !halted_m && if_valid && !hz;
    case (ccc)
      0: taken = !z_f;
      1: taken = z_f;
      2: taken = !z_f && (n_f == v_f);
      3: taken = (n_f != v_f);
      4: taken = (n_f == v_f);
      5: taken = z_f || (n_f != v_f);
      6: taken = v_f;
      default: taken = 1'b1;
    endcase
    e_brt = acc && (op == 12 || op == 13) && taken;
    imm = int'(if_instr[8:0]);
    off = (imm >= 256) ? imm - 512 : imm;
    e_bra = (op == 13) ? 16'(mval(rs)) : 16'(int'(if_pc2) + 2 * off);
    e_halt = acc && (op == 15);
    i4 = (rt >= 8) ? rt - 16 : rt;
    nx = '0;
    if (acc && op != 12 && op != 13 && op != 15) begin
      nx.valid = 1'b1; nx.rw = 1'b1; nx.dst = 4'(rd);
      if (op < 8) begin
        nx.a = 16'(mval(rs)); nx.b = 16'(mval(rt)); nx.op = 4'(op);
        nx.ez = 1'b1; nx.en = 1'b1; nx.ev = (op < 2);
      end else begin
        case (op)
          8: begin nx.a = 16'(mval(rs)); nx.b = 16'(i4); nx.mr = 1'b1; nx.m2r = 1'b1; end
          9: begin
            nx.a = 16'(mval(rs)); nx.b = 16'(i4); nx.sw = 16'(mval(rd));
            nx.mw = 1'b1; nx.rw = 1'b0; nx.dst = '0;
          end
          10: begin
            nx.a = 16'(mval(rs)); nx.b = 16'(i4); nx.ez = 1'b1; nx.en = 1'b1; nx.ev = 1'b1;
          end
          11: nx.b = {8'h00, if_instr[7:0]};
          14: nx.a = if_pc2;
          default: ;
        endcase
      end
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf_m[i] = 0;
      mex = '0;
      halted_m = 1'b0;
    end else begin
      if (wb_en && wb_reg != 0) rf_m[wb_reg] = int'(wb_data);
      if (e_halt) halted_m = 1'b1;
      mex = nx;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0; if_valid = 1'b1; if_instr = 16'hCE00;
    tick();
    chk++; if (id_ready !== 1'b0) begin err++; $display("FAIL reset_ready: got %b want 0", id_ready); end
    chk++; if (ex_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    chk++; if (hlt !== 1'b0) begin err++; $display("FAIL reset_hlt: got %b want 0", hlt); end
    chk++; if (br_taken !== 1'b0) begin err++; $display("FAIL reset_br: got %b want 0", br_taken); end
    chk++; if (ex_rw !== 1'b0) begin err++; $display("FAIL reset_rw: got %b want 0", ex_rw); end
    rst_n = 1'b1; if_valid = 1'b0;
    #1;
    chk++; if (id_ready !== 1'b1) begin err++; $display("FAIL idle_ready: got %b want 1", id_ready); end
  endtask

  task automatic test_add();
    do_reset();
    wb_en = 1'b1; wb_reg = 4'd2; wb_data = 16'd5; tick();
    wb_reg = 4'd3; wb_data = 16'd7; tick();
    wb_en = 1'b0; if_valid = 1'b1; if_instr = 16'h0123;
    #1;
    chk++; if (id_ready !== 1'b1) begin err++; $display("FAIL add_ready: got %b want 1", id_ready); end
    tick();
    chk++; if (ex_valid !== 1'b1) begin err++; $display("FAIL add_valid: got %b want 1", ex_valid); end
    chk++; if (ex_a !== 16'd5) begin err++; $display("FAIL add_a: got %h want 0005", ex_a); end
    chk++; if (ex_b !== 16'd7) begin err++; $display("FAIL add_b: got %h want 0007", ex_b); end
    chk++; if (ex_rw !== 1'b1) begin err++; $display("FAIL add_rw: got %b want 1", ex_rw); end
    chk++; if (ex_dst !== 4'd1) begin err++; $display("FAIL add_dst: got %h want 1", ex_dst); end
    if_valid = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    if_valid = 1'b1; if_instr = 16'h8410;
    tick();
    chk++; if (ex_mr !== 1'b1) begin err++; $display("FAIL lw_mr: got %b want 1", ex_mr); end
    if_instr = 16'h0541;
    #1;
    chk++; if (id_ready !== 1'b0) begin err++; $display("FAIL lu_stall: got %b want 0", id_ready); end
    tick();
    chk++; if (ex_valid !== 1'b0) begin err++; $display("FAIL lu_bubble: got %b want 0", ex_valid); end
    chk++; if (id_ready !== 1'b1) begin err++; $display("FAIL lu_release: got %b want 1", id_ready); end
    tick();
    chk++; if (ex_valid !== 1'b1) begin err++; $display("FAIL lu_accept: got %b want 1", ex_valid); end
    chk++; if (ex_dst !== 4'd5) begin err++; $display("FAIL lu_dst: got %h want 5", ex_dst); end
    if_valid = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    wb_en = 1'b1; wb_reg = 4'd2; wb_data = 16'h0055;
    ex_fwd_en = 1'b1; ex_fwd_reg = 4'd2; ex_fwd_data = 16'h00AA;
    if_valid = 1'b1; if_instr = 16'h0620;
    #1;
    chk++; if (id_ready !== 1'b1) begin err++; $display("FAIL fwd_ready: got %b want 1", id_ready); end
    chk++; if (nf_id_ready !== 1'b0) begin err++; $display("FAIL nf_stall: got %b want 0", nf_id_ready); end
    tick();
    chk++; if (ex_a !== 16'h00AA) begin err++; $display("FAIL fwd_a: got %h want 00aa", ex_a); end
    chk++; if (nf_ex_valid !== 1'b0) begin err++; $display("FAIL nf_bubble: got %b want 0", nf_ex_valid); end
    chk++; if (nf_id_ready !== 1'b0) begin err++; $display("FAIL nf_hold: got %b want 0", nf_id_ready); end
    wb_en = 1'b0; ex_fwd_en = 1'b0;
    #1;
    chk++; if (nf_id_ready !== 1'b1) begin err++; $display("FAIL nf_clear: got %b want 1", nf_id_ready); end
    tick();
    chk++; if (nf_ex_a !== 16'h0055) begin err++; $display("FAIL nf_a: got %h want 0055", nf_ex_a); end
    chk++; if (ex_a !== 16'h0055) begin err++; $display("FAIL rf_a: got %h want 0055", ex_a); end
    if_valid = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    if_valid = 1'b1; if_instr = 16'hC3FE; if_pc2 = 16'h0010; z_f = 1'b1;
    #1;
    chk++; if (br_taken !== 1'b1) begin err++; $display("FAIL beq_taken: got %b want 1", br_taken); end
    chk++; if (br_addr !== 16'h000C) begin err++; $display("FAIL beq_addr: got %h want 000c", br_addr); end
    tick();
    chk++; if (ex_valid !== 1'b0) begin err++; $display("FAIL br_bubble: got %b want 0", ex_valid); end
    ex_flag_pend = 1'b1;
    #1;
    chk++; if (br_taken !== 1'b0) begin err++; $display("FAIL flag_br: got %b want 0", br_taken); end
    chk++; if (id_ready !== 1'b0) begin err++; $display("FAIL flag_stall: got %b want 0", id_ready); end
    tick();
    ex_flag_pend = 1'b0;
    #1;
    chk++; if (br_taken !== 1'b1) begin err++; $display("FAIL flag_after: got %b want 1", br_taken); end
    z_f = 1'b0;
    #1;
    chk++; if (br_taken !== 1'b0) begin err++; $display("FAIL bne_nt: got %b want 0", br_taken); end
    chk++; if (id_ready !== 1'b1) begin err++; $display("FAIL nt_ready: got %b want 1", id_ready); end
    if_instr = 16'hCF00; if_pc2 = 16'h0002;
    #1;
    chk++; if (br_addr !== 16'hFE02) begin err++; $display("FAIL b_wrap: got %h want fe02", br_addr); end
    ex_flag_pend = 1'b1; if_instr = 16'hDE30;
    wb_en = 1'b1; wb_reg = 4'd3; wb_data = 16'h0042;
    #1;
    chk++; if (br_taken !== 1'b1) begin err++; $display("FAIL br_taken: got %b want 1", br_taken); end
    chk++; if (br_addr !== 16'h0042) begin err++; $display("FAIL br_addr: got %h want 0042", br_addr); end
    idle_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    if_valid = 1'b1; if_instr = 16'hF000;
    #1;
    chk++; if (id_ready !== 1'b1) begin err++; $display("FAIL hlt_ready: got %b want 1", id_ready); end
    tick();
    chk++; if (hlt !== 1'b1) begin err++; $display("FAIL hlt_set: got %b want 1", hlt); end
    if_instr = 16'hCE00;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk++; if (hlt !== 1'b1) begin err++; $display("FAIL hlt_hold: got %b want 1", hlt); end
      chk++; if (id_ready !== 1'b0) begin err++; $display("FAIL hlt_ready0: got %b want 0", id_ready); end
      chk++; if (br_taken !== 1'b0) begin err++; $display("FAIL hlt_br: got %b want 0", br_taken); end
      tick();
      chk++; if (ex_valid !== 1'b0) begin err++; $display("FAIL hlt_bub: got %b want 0", ex_valid); end
    end
    rst_n = 1'b0;
    tick();
    chk++; if (hlt !== 1'b0) begin err++; $display("FAIL hlt_rst: got %b want 0", hlt); end
    chk++; if (ex_valid !== 1'b0) begin err++; $display("FAIL hlt_rst_v: got %b want 0", ex_valid); end
    rst_n = 1'b1; if_instr = 16'h0123;
    #1;
    chk++; if (id_ready !== 1'b1) begin err++; $display("FAIL resume: got %b want 1", id_ready); end
    tick();
    chk++; if (ex_valid !== 1'b1) begin err++; $display("FAIL resume_v: got %b want 1", ex_valid); end
    if_valid = 1'b0;
  endtask

  task automatic test_regfile();
    do_reset();
    wb_en = 1'b1; wb_reg = 4'd0; wb_data = 16'hFFFF;
    if_valid = 1'b1; if_instr = 16'h0100;
    tick();
    chk++; if (ex_a !== 16'h0) begin err++; $display("FAIL r0_wt: got %h want 0000", ex_a); end
    wb_en = 1'b0;
    tick();
    chk++; if (ex_b !== 16'h0) begin err++; $display("FAIL r0_rf: got %h want 0000", ex_b); end
    wb_en = 1'b1; wb_reg = 4'd7; wb_data = 16'h1234; if_instr = 16'h0177;
    tick();
    chk++; if (ex_a !== 16'h1234) begin err++; $display("FAIL wt_a: got %h want 1234", ex_a); end
    chk++; if (ex_b !== 16'h1234) begin err++; $display("FAIL wt_b: got %h want 1234", ex_b); end
    wb_en = 1'b0; if_instr = 16'hE900; if_pc2 = 16'h0100;
    tick();
    chk++; if (ex_a !== 16'h0100) begin err++; $display("FAIL pcs_a: got %h want 0100", ex_a); end
    chk++; if (ex_b !== 16'h0) begin err++; $display("FAIL pcs_b: got %h want 0000", ex_b); end
    chk++; if (ex_dst !== 4'd9) begin err++; $display("FAIL pcs_dst: got %h want 9", ex_dst); end
    if_instr = 16'h9713;
    tick();
    chk++; if (ex_mw !== 1'b1) begin err++; $display("FAIL sw_mw: got %b want 1", ex_mw); end
    chk++; if (ex_sw !== 16'h1234) begin err++; $display("FAIL sw_data: got %h want 1234", ex_sw); end
    chk++; if (ex_rw !== 1'b0) begin err++; $display("FAIL sw_rw: got %b want 0", ex_rw); end
    if_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] ins;
    do_reset();
    for (int i = 0; i < 16; i++) rf_m[i] = 0;
    mex = '0; halted_m = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if_valid = ($urandom_range(0, 7) != 0);
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF && $urandom_range(0, 31) != 0) ins[15:12] = 4'h0;
      if (ins[15:12] != 4'hC && ins[15:12] != 4'hD) ins = ins & 16'hF777;
      if_instr = ins;
      if_pc2 = 16'($urandom);
      wb_en = $urandom_range(0, 1) == 1; wb_reg = 4'($urandom_range(0, 7));
      wb_data = 16'($urandom);
      ex_fwd_en = $urandom_range(0, 1) == 1; ex_fwd_reg = 4'($urandom_range(0, 7));
      ex_fwd_data = 16'($urandom);
      ex_flag_pend = ($urandom_range(0, 3) == 0);
      z_f = $urandom_range(0, 1) == 1; n_f = $urandom_range(0, 1) == 1;
      v_f = $urandom_range(0, 1) == 1;
      #1;
      predict();
      chk++;
      if (id_ready !== e_ready) begin
        err++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, id_ready, e_ready);
      end
      chk++;
      if (br_taken !== e_brt) begin
        err++; $display("FAIL rnd_br c=%0d: got %b want %b", c, br_taken, e_brt);
      end
      if (e_brt) begin
        chk++;
        if (br_addr !== e_bra) begin
          err++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, br_addr, e_bra);
        end
      end
      @(posedge clk);
      model_commit();
      #1;
      chk++;
      if (obs !== mex) begin
        err++; $display("FAIL rnd_bank c=%0d: got %h want %h", c, obs, mex);
      end
      chk++;
      if (hlt !== halted_m) begin
        err++; $display("FAIL rnd_hlt c=%0d: got %b want %b", c, hlt, halted_m);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_load_use();
    test_forward();
    test_branch();
    test_halt();
    test_regfile();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
